// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch controller sitting between the program counter block and a
// variable-latency instruction memory. It reads i_pc and fetches one word over
// a req/ack handshake, retrying after a bounded wait. The word is held for
// downstream on a valid/ready handshake. When the word is accepted it strobes
// o_pc_en and decodes relative branches into o_pc_src / o_immediate.
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_reset        asynchronous active-high reset
//   i_pc           current program counter
//   o_mem_req      memory read request (high in REQ)
//   o_mem_addr     read address; follows i_pc combinationally in REQ, else 0
//   i_mem_ack      read data valid this cycle (ignored outside REQ)
//   i_mem_rdata    read data
//   o_instr        fetched instruction register
//   o_instr_valid  o_instr is valid (high in HOLD)
//   i_instr_ready  downstream accepts o_instr (ignored outside HOLD)
//   i_zero_flag    condition for the conditional branch
//   o_immediate    branch offset to the pc block
//   o_pc_src       1 = pc takes PC + immediate, 0 = PC + 1
//   o_pc_en        one-cycle pc update strobe per accepted instruction
//   o_fetch_err    sticky memory-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int AW      = 8,
    parameter int IW      = 16,
    parameter int TIMEOUT = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_pc,
    output logic          o_mem_req,
    output logic [AW-1:0] o_mem_addr,
    input  logic          i_mem_ack,
    input  logic [IW-1:0] i_mem_rdata,
    output logic [IW-1:0] o_instr,
    output logic          o_instr_valid,
    input  logic          i_instr_ready,
    input  logic          i_zero_flag,
    output logic [AW-1:0] o_immediate,
    output logic          o_pc_src,
    output logic          o_pc_en,
    output logic          o_fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RETRY = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] OP_BR = 4'hB;
    localparam logic [3:0] OP_BZ = 4'hC;

    // The counter value seen during the TIMEOUT-th waiting cycle; giving up on
    // that cycle means exactly TIMEOUT request cycles go unanswered.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_wait_cnt;
    logic [7:0]    w_wait_cnt_next;
    logic [IW-1:0] r_instr;
    logic [IW-1:0] w_instr_next;
    logic          r_fetch_err;
    logic          w_fetch_err_next;

    logic [3:0]    w_opcode;
    logic [AW-1:0] w_offset;

    assign w_opcode = r_instr[IW-1:IW-4];
    assign w_offset = r_instr[AW-1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_instr     <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_instr     <= w_instr_next;
            r_fetch_err <= w_fetch_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_wait_cnt_next  = r_wait_cnt;
        w_instr_next     = r_instr;
        w_fetch_err_next = r_fetch_err;
        o_mem_req        = 1'b0;
        o_mem_addr       = '0;
        o_instr_valid    = 1'b0;
        o_pc_en          = 1'b0;
        o_pc_src         = 1'b0;
        o_immediate      = '0;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
            end
            S_REQ: begin
                o_mem_req  = 1'b1;
                o_mem_addr = i_pc;
                // Ack is tested first so an ack on the last allowed cycle
                // still captures data and raises no error.
                if (i_mem_ack) begin
                    w_instr_next    = i_mem_rdata;
                    w_wait_cnt_next = '0;
                    w_state_next    = S_HOLD;
                end else if (r_wait_cnt == LAST_WAIT) begin
                    w_fetch_err_next = 1'b1;
                    w_wait_cnt_next  = '0;
                    w_state_next     = S_RETRY;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 8'd1;
                end
            end
            S_RETRY: begin
                // One dead cycle with the request dropped, then re-issue the
                // same address (pc has not moved).
                w_state_next = S_REQ;
            end
            S_HOLD: begin
                o_instr_valid = 1'b1;
                if (i_instr_ready) begin
                    o_pc_en      = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Branch decode is only presented alongside the pc strobe so that pc
        // never sees a stray offset.
        if (o_pc_en) begin
            if (w_opcode == OP_BR) begin
                o_pc_src    = 1'b1;
                o_immediate = w_offset;
            end else if (w_opcode == OP_BZ) begin
                o_pc_src    = i_zero_flag;
                o_immediate = i_zero_flag ? w_offset : '0;
            end
        end
    end

    assign o_instr     = r_instr;
    assign o_fetch_err = r_fetch_err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl. A small pc model closes the loop so that
// branch offsets show up on later fetch addresses. Each accepted fetch pushes
// its expected {instr, pc_src, immediate} into a queue; a monitor pops and
// compares on every pc_en pulse. Directed checks cover reset, addressing,
// timeout/retry, stalls and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pc_model;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        instr_ready = 1'b0;
    logic        zero_flag = 1'b0;

    logic        o_mem_req;
    logic [7:0]  o_mem_addr;
    logic [15:0] o_instr;
    logic        o_instr_valid;
    logic [7:0]  o_immediate;
    logic        o_pc_src;
    logic        o_pc_en;
    logic        o_fetch_err;

    typedef struct packed {
        logic [15:0] instr;
        logic        src;
        logic [7:0]  imm;
    } txn_t;

    txn_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.AW(8), .IW(16), .TIMEOUT(16)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_pc          (pc_model),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ack     (mem_ack),
        .i_mem_rdata   (mem_rdata),
        .o_instr       (o_instr),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (instr_ready),
        .i_zero_flag   (zero_flag),
        .o_immediate   (o_immediate),
        .o_pc_src      (o_pc_src),
        .o_pc_en       (o_pc_en),
        .o_fetch_err   (o_fetch_err)
    );

    // Behaviour of the pc block: modulo-256 relative branch or increment.
    always @(posedge clk or posedge reset) begin
        if (reset)
            pc_model <= 8'h00;
        else if (o_pc_en)
            pc_model <= o_pc_src ? (pc_model + o_immediate) : (pc_model + 8'h01);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pc_en pulse is one delivered instruction.
    always @(negedge clk) begin
        if (o_pc_en === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pc_en: got instr %h with empty scoreboard at %0t", o_instr, $time);
            end else begin
                txn_t e;
                e = sb.pop_front();
                $display("txn instr=%h pc_src=%0d imm=%h (exp %h/%0d/%h)",
                         o_instr, o_pc_src, o_immediate, e.instr, e.src, e.imm);
                check("txn_instr", 32'(o_instr), 32'(e.instr));
                check("txn_pc_src", 32'(o_pc_src), 32'(e.src));
                check("txn_immediate", 32'(o_immediate), 32'(e.imm));
            end
        end
    end

    // Called #1 after the edge that entered REQ. Acks after wait_n idle REQ
    // cycles, optionally stalls stall_n HOLD cycles with stray acks, then
    // accepts with zero_flag = zf.
    task automatic do_fetch(input logic [15:0] data, input int wait_n, input int stall_n,
                            input logic zf, input logic [7:0] addr,
                            input logic src, input logic [7:0] imm);
        @(negedge clk);
        check("req_mem_req", 32'(o_mem_req), 32'd1);
        check("req_mem_addr", 32'(o_mem_addr), 32'(addr));
        repeat (wait_n) begin
            @(posedge clk); #1;
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < stall_n; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = 16'hDEAD;
            @(negedge clk);
            check("stall_valid", 32'(o_instr_valid), 32'd1);
            check("stall_instr", 32'(o_instr), 32'(data));
            check("stall_pc_en", 32'(o_pc_en), 32'd0);
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = '0;
        end
        sb.push_back('{instr: data, src: src, imm: imm});
        zero_flag   = zf;
        instr_ready = 1'b1;
        @(negedge clk);
        check("hold_valid", 32'(o_instr_valid), 32'd1);
        check("hold_instr", 32'(o_instr), 32'(data));
        @(posedge clk); #1;
        instr_ready = 1'b0;
        zero_flag   = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        check("rst_instr", 32'(o_instr), 32'd0);
        check("rst_valid", 32'(o_instr_valid), 32'd0);
        check("rst_pc_en", 32'(o_pc_en), 32'd0);
        check("rst_pc_src", 32'(o_pc_src), 32'd0);
        check("rst_immediate", 32'(o_immediate), 32'd0);
        check("rst_fetch_err", 32'(o_fetch_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_mem_req", 32'(o_mem_req), 32'd0);
        @(posedge clk); #1;

        // Plain, BR, BZ taken, BZ not taken (ack on the 16th cycle: ack wins)
        do_fetch(16'h1234, 2, 0, 1'b0, 8'h00, 1'b0, 8'h00);  // pc -> 01
        do_fetch(16'hB007, 0, 0, 1'b0, 8'h01, 1'b1, 8'h07);  // pc -> 08
        do_fetch(16'hC0FE, 0, 0, 1'b1, 8'h08, 1'b1, 8'hFE);  // pc -> 06
        do_fetch(16'hC0FE, 15, 0, 1'b0, 8'h06, 1'b0, 8'h00); // pc -> 07

        // Timeout: 16 unanswered REQ cycles, one RETRY cycle, same address
        @(negedge clk);
        check("ack_wins_no_err", 32'(o_fetch_err), 32'd0);
        repeat (15) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("to_last_req", 32'(o_mem_req), 32'd1);
        check("to_no_err_yet", 32'(o_fetch_err), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("retry_mem_req", 32'(o_mem_req), 32'd0);
        check("retry_fetch_err", 32'(o_fetch_err), 32'd1);
        check("retry_valid", 32'(o_instr_valid), 32'd0);
        @(posedge clk); #1;
        do_fetch(16'h3055, 0, 0, 1'b0, 8'h07, 1'b0, 8'h00);  // pc -> 08
        @(negedge clk);
        check("err_sticky", 32'(o_fetch_err), 32'd1);

        // Stall five cycles with stray acks, then one accept
        do_fetch(16'hB0FF, 0, 5, 1'b0, 8'h08, 1'b1, 8'hFF);  // pc -> 07
        @(negedge clk);
        check("single_pc_en", 32'(o_pc_en), 32'd0);
        check("wrap_mem_addr", 32'(o_mem_addr), 32'h07);

        // Asynchronous reset while holding an instruction
        mem_ack   = 1'b1;
        mem_rdata = 16'h1111;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        check("pre_rst_valid", 32'(o_instr_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(o_instr_valid), 32'd0);
        check("arst_mem_req", 32'(o_mem_req), 32'd0);
        check("arst_fetch_err", 32'(o_fetch_err), 32'd0);
        check("arst_instr", 32'(o_instr), 32'd0);
        instr_ready = 1'b1;
        #1;
        check("arst_pc_en", 32'(o_pc_en), 32'd0);
        @(posedge clk); #1;
        reset       = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(o_mem_req), 32'd0);
        @(posedge clk); #1;
        do_fetch(16'h0042, 1, 0, 1'b0, 8'h00, 1'b0, 8'h00);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
